// File: rtl/uut_run_sequencer_pkg.sv
// Shared types and debug-word offsets for the UUT run sequencer slice.
package uut_run_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RSTU,
        RUN,
        DONE,
        TOUT
    } state_t;

    // Statistic/status words follow the hash words on the debug mux.
    localparam int DBG_CYC_LAST = 0;
    localparam int DBG_CYC_MIN  = 1;
    localparam int DBG_CYC_MAX  = 2;
    localparam int DBG_STATUS   = 3;

endpackage

// File: rtl/uut_run_sequencer_if.sv
// Hookup between the run sequencer (master) and the hash core under test (slave).
interface uut_run_sequencer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int N          = 256
);
    logic                  rst_uut;
    logic [DATA_WIDTH-1:0] msg_uut;
    logic                  end_uut;
    logic [N-1:0]          hash_uut;

    modport master (
        output rst_uut,
        output msg_uut,
        input  end_uut,
        input  hash_uut
    );

    modport slave (
        input  rst_uut,
        input  msg_uut,
        output end_uut,
        output hash_uut
    );
endinterface

// File: rtl/uut_cycle_stats.sv
// Last/min/max latency tracker; clr re-arms min/max for a new start, upd folds in one run.
module uut_cycle_stats #(
    parameter int CYCLE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               upd,
    input  logic [CYCLE_W-1:0] val,
    output logic [CYCLE_W-1:0] cyc_last,
    output logic [CYCLE_W-1:0] cyc_min,
    output logic [CYCLE_W-1:0] cyc_max
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_last <= '0;
            cyc_min  <= '1;
            cyc_max  <= '0;
        end else if (clr) begin
            cyc_min <= '1;
            cyc_max <= '0;
        end else if (upd) begin
            cyc_last <= val;
            if (val < cyc_min) cyc_min <= val;
            if (val > cyc_max) cyc_max <= val;
        end
    end

endmodule

// File: rtl/uut_run_sequencer.sv
// Repeated-run sequencer for a hash core: reset/run/measure NUM_RUNS times, capture digest.
// Optional digest comparator enabled by defining UUT_RUN_SEQUENCER_COMPARE_EN.
module uut_run_sequencer
    import uut_run_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int N              = 256,
    parameter int CYCLE_W        = 32,
    parameter int RST_CYCLES     = 4,
    parameter int NUM_RUNS       = 1,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int SEL_W          = $clog2(N/32+4)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] msg_i,
    input  logic [N-1:0]          expected_i,
    uut_run_sequencer_if.master   uut,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_o,
    output logic                  match_o,
    output logic [N-1:0]          hash_o,
    output logic [CYCLE_W-1:0]    cycles_last,
    output logic [CYCLE_W-1:0]    cycles_min,
    output logic [CYCLE_W-1:0]    cycles_max,
    input  logic [SEL_W-1:0]      dbg_sel,
    output logic [31:0]           debug_o
);

    localparam int HWORDS = N / 32;
    localparam int RST_W  = $clog2(RST_CYCLES + 1);
    localparam int RUN_W  = $clog2(NUM_RUNS + 1);
    localparam int WI     = (HWORDS > 1) ? $clog2(HWORDS) : 1;

    localparam logic [RST_W-1:0]   RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [RUN_W-1:0]   RUN_LAST = RUN_W'(NUM_RUNS - 1);
    localparam logic [CYCLE_W-1:0] TO_VAL   = CYCLE_W'(TIMEOUT_CYCLES);
    localparam bit                 TO_EN    = (TIMEOUT_CYCLES != 0);

    localparam logic [SEL_W-1:0] SEL_HW     = SEL_W'(HWORDS);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(HWORDS + DBG_CYC_LAST);
    localparam logic [SEL_W-1:0] SEL_MIN    = SEL_W'(HWORDS + DBG_CYC_MIN);
    localparam logic [SEL_W-1:0] SEL_MAX    = SEL_W'(HWORDS + DBG_CYC_MAX);
    localparam logic [SEL_W-1:0] SEL_STATUS = SEL_W'(HWORDS + DBG_STATUS);

    state_t             state, state_nx;
    logic [RST_W-1:0]   rst_cnt;
    logic [CYCLE_W-1:0] cnt;
    logic [RUN_W-1:0]   run_cnt;
    logic               accept;
    logic               capture;
    logic               to_hit;
    logic [31:0]        debug_p0;
    logic [31:0]        hw [HWORDS];

    // Zero-extends or truncates a statistic to the 32-bit display word.
    function automatic logic [31:0] fit32(input logic [CYCLE_W-1:0] v);
        logic [CYCLE_W+31:0] t;
        t = {32'b0, v};
        return t[31:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        to_hit   = TO_EN && (cnt == TO_VAL);
        case (state)
            IDLE, DONE, TOUT: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RSTU;
                end
            end
            RSTU: if (rst_cnt == RST_LAST) state_nx = RUN;
            RUN: begin
                // Completion takes priority over a timeout in the same cycle.
                if (uut.end_uut) begin
                    capture  = 1'b1;
                    state_nx = (run_cnt == RUN_LAST) ? DONE : RSTU;
                end else if (to_hit) begin
                    state_nx = TOUT;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign uut.rst_uut = (state != RUN);
    assign busy        = (state == RSTU) || (state == RUN);
    assign done        = (state == DONE);
    assign timeout_o   = (state == TOUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_cnt     <= '0;
            cnt         <= '0;
            run_cnt     <= '0;
            uut.msg_uut <= '0;
            hash_o      <= '0;
        end else begin
            rst_cnt <= (state == RSTU) ? rst_cnt + 1'b1 : '0;
            // cnt enters RUN at 1 so a core finishing on its k-th cycle reports k.
            if (state == RSTU)
                cnt <= CYCLE_W'(1);
            else if ((state == RUN) && !uut.end_uut && (cnt != '1))
                cnt <= cnt + 1'b1;
            if (accept) begin
                uut.msg_uut <= msg_i;
                run_cnt     <= '0;
            end
            if (capture) begin
                hash_o  <= uut.hash_uut;
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    uut_cycle_stats #(
        .CYCLE_W (CYCLE_W)
    ) u_stats (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .upd      (capture),
        .val      (cnt),
        .cyc_last (cycles_last),
        .cyc_min  (cycles_min),
        .cyc_max  (cycles_max)
    );

`ifdef UUT_RUN_SEQUENCER_COMPARE_EN
    // Match is the running AND over all runs of one start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   match_o <= 1'b0;
        else if (accept)            match_o <= 1'b1;
        else if (capture)           match_o <= match_o & (uut.hash_uut == expected_i);
        else if (state_nx == TOUT)  match_o <= 1'b0;
    end
`else
    logic unused_expected;
    assign unused_expected = ^expected_i;
    assign match_o         = 1'b0;
`endif

    for (genvar g = 0; g < HWORDS; g++) begin : g_words
        assign hw[g] = hash_o[32*g +: 32];
    end

    always_comb begin
        debug_p0 = '0;
        if (dbg_sel < SEL_HW) begin
            debug_p0 = hw[dbg_sel[WI-1:0]];
        end else begin
            case (dbg_sel)
                SEL_LAST:   debug_p0 = fit32(cycles_last);
                SEL_MIN:    debug_p0 = fit32(cycles_min);
                SEL_MAX:    debug_p0 = fit32(cycles_max);
                SEL_STATUS: debug_p0 = {28'b0, match_o, timeout_o, done, busy};
                default:    debug_p0 = '0;
            endcase
        end
    end

    // Registered debug word: one cycle behind select and sources.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) debug_o <= '0;
        else      debug_o <= debug_p0;
    end

endmodule
